// File: rtl/spi_master_engine.sv
// spi_master_engine: mode-0 single-word SPI master shift engine driven by a divider tick.
// Optional build macro SPI_MASTER_LSB_FIRST_EN selects LSB-first shifting in both directions.
module spi_master_engine #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int CW = $clog2(2 * DATA_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic              load_bit;
  logic              next_bit;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign load_bit = tx_data[0];
  assign next_bit = tx_sr[1];
  assign tx_shift = tx_sr >> 1;
  assign rx_shift = {miso, rx_sr[DATA_W-1:1]};
`else
  assign load_bit = tx_data[DATA_W-1];
  assign next_bit = tx_sr[DATA_W-2];
  assign tx_shift = tx_sr << 1;
  assign rx_shift = {rx_sr[DATA_W-2:0], miso};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; tick is ignored while idle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   if (tick) state_nx = XFER;
      XFER:    if (tick && cnt == LAST) state_nx = HOLD;
      HOLD:    if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shift datapath and registered SPI/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            tx_sr <= tx_data;
            mosi  <= load_bit;
            cs_n  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        XFER: begin
          if (tick) begin
            sclk <= ~sclk;
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (!sclk) begin
              rx_sr <= rx_shift;
            end else if (cnt != LAST) begin
              mosi  <= next_bit;
              tx_sr <= tx_shift;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sr;
            mosi    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// tb_spi_master_engine: randomized self-checking bench for spi_master_engine.
// Reference model works on whole words and bit positions; honours SPI_MASTER_LSB_FIRST_EN.
`timescale 1ns/1ps
module tb_spi_master_engine;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         tick;
  logic         start;
  logic [W-1:0] tx_data;
  logic         miso;
  logic         sclk;
  logic         mosi;
  logic         cs_n;
  logic         busy;
  logic         done;
  logic [W-1:0] rx_data;

  int total = 0;
  int bad = 0;

  int td = 4;
  bit tick_en = 0;
  int tphase = 0;

  bit           loop = 1;
  logic [W-1:0] slave_word = '0;
  int           slave_idx = 0;
  logic         sbit;

  int cyc = 0;
  int tick_cnt = 0;
  int ticks_at_done = 0;
  int rise_cnt = 0;
  int last_rise = 0;
  int min_per = 1000000;
  int max_per = 0;
  int done_cnt = 0;
  int mosi_zero_busy = 0;
  int sclk_in_rst = 0;
  int cs_run = 0;
  int last_gap = -1;
  logic [W-1:0] last_rx = '0;
  logic prev_sclk = 1'b0;
  logic prev_busy = 1'b0;
  bit mosi_seq[$];

  spi_master_engine #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .tx_data(tx_data), .miso(miso), .sclk(sclk), .mosi(mosi),
    .cs_n(cs_n), .busy(busy), .done(done), .rx_data(rx_data)
  );

  // Wire-order position of the i-th bit on the line.
  function automatic int pos(input int i);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return i;
`else
    return W - 1 - i;
`endif
  endfunction

  // Word rebuilt from the mosi bits seen at sclk rising edges.
  function automatic logic [W-1:0] seq_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < mosi_seq.size() && i < W; i++) w[pos(i)] = mosi_seq[i];
    return w;
  endfunction

  assign sbit = (slave_idx < W) ? slave_word[pos(slave_idx)] : 1'b0;
  assign miso = loop ? mosi : sbit;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divider stand-in: one-clock tick every td clocks.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        tphase = (tphase + 1) % td;
        tick = (tphase == 0);
      end else begin
        tphase = 0;
        tick = 1'b0;
      end
    end
  end

  // Observer sampling just after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        tick_cnt = 0;
        if (sclk) sclk_in_rst++;
      end else if (tick && prev_busy) begin
        tick_cnt++;
      end
      if (sclk && !prev_sclk) begin
        if (rise_cnt > 0) begin
          if (cyc - last_rise < min_per) min_per = cyc - last_rise;
          if (cyc - last_rise > max_per) max_per = cyc - last_rise;
        end
        last_rise = cyc;
        rise_cnt++;
        mosi_seq.push_back(mosi);
      end
      if (cs_n) slave_idx = 0;
      else if (prev_sclk && !sclk) slave_idx++;
      if (done) begin
        done_cnt++;
        ticks_at_done = tick_cnt;
        tick_cnt = 0;
        last_rx = rx_data;
      end
      if (busy && !mosi) mosi_zero_busy++;
      if (cs_n) cs_run++;
      else if (cs_run > 0) begin
        last_gap = cs_run;
        cs_run = 0;
      end
      prev_sclk = sclk;
      prev_busy = busy;
    end
  end

  task automatic clear_mon();
    tick_cnt = 0;
    ticks_at_done = -1;
    rise_cnt = 0;
    min_per = 1000000;
    max_per = 0;
    done_cnt = 0;
    mosi_zero_busy = 0;
    sclk_in_rst = 0;
    last_gap = -1;
    mosi_seq.delete();
  endtask

  task automatic launch(input logic [W-1:0] d);
    @(negedge clk);
    tx_data = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int limit);
    int k = 0;
    while (done_cnt < n && k < limit) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tx_data = 8'hFF;
    td = 1;
    tick_en = 1;
    clear_mon();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    total += 6;
    if (sclk !== 1'b0) begin bad++; $display("FAIL rst_sclk got %b want 0", sclk); end
    if (cs_n !== 1'b1) begin bad++; $display("FAIL rst_cs_n got %b want 1", cs_n); end
    if (mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi got %b want 0", mosi); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", done); end
    if (rx_data !== '0) begin bad++; $display("FAIL rst_rx got %h want 00", rx_data); end
    rst = 1'b0;
    start = 1'b0;
    tick_en = 0;
    repeat (4) @(negedge clk);
    total += 2;
    if (sclk_in_rst != 0) begin bad++; $display("FAIL rst_sclk_act got %0d want 0", sclk_in_rst); end
    if (cs_n !== 1'b1) begin bad++; $display("FAIL rst_idle_cs got %b want 1", cs_n); end
  endtask

  task automatic test_loopback();
    logic [W-1:0] d = 8'hA5;
    loop = 1;
    td = 4;
    tick_en = 1;
    clear_mon();
    launch(d);
    total += 2;
    if (cs_n !== 1'b0) begin bad++; $display("FAIL lb_cs_lat got %b want 0", cs_n); end
    if (busy !== 1'b1) begin bad++; $display("FAIL lb_busy_lat got %b want 1", busy); end
    wait_done(1, 400);
    total += 8;
    if (done_cnt != 1) begin bad++; $display("FAIL lb_done got %0d want 1", done_cnt); end
    if (ticks_at_done != 2 * W + 2) begin bad++; $display("FAIL lb_ticks got %0d want %0d", ticks_at_done, 2 * W + 2); end
    if (rise_cnt != W) begin bad++; $display("FAIL lb_rises got %0d want %0d", rise_cnt, W); end
    if (min_per != 8 || max_per != 8) begin bad++; $display("FAIL lb_period got %0d..%0d want 8", min_per, max_per); end
    if (seq_word() !== d) begin bad++; $display("FAIL lb_mosi_seq got %h want %h", seq_word(), d); end
    if (last_rx !== d) begin bad++; $display("FAIL lb_rx got %h want %h", last_rx, d); end
    if (busy !== 1'b0) begin bad++; $display("FAIL lb_busy_end got %b want 0", busy); end
    if (cs_n !== 1'b1) begin bad++; $display("FAIL lb_cs_end got %b want 1", cs_n); end
  endtask

  task automatic test_slave();
    loop = 0;
    slave_word = 8'h3C;
    td = 3;
    clear_mon();
    launch(8'hFF);
    wait_done(1, 400);
    total += 3;
    if (done_cnt != 1) begin bad++; $display("FAIL sl_done got %0d want 1", done_cnt); end
    if (last_rx !== 8'h3C) begin bad++; $display("FAIL sl_rx got %h want 3c", last_rx); end
    if (mosi_zero_busy != 0) begin bad++; $display("FAIL sl_mosi_const got %0d lows want 0", mosi_zero_busy); end
    loop = 1;
  endtask

  task automatic test_busy_start();
    logic [W-1:0] d = W'($urandom_range(1, 255));
    int k = 0;
    td = 2;
    clear_mon();
    launch(d);
    while (rise_cnt < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    tx_data = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, 400);
    repeat (60) @(negedge clk);
    total += 4;
    if (done_cnt != 1) begin bad++; $display("FAIL bs_done got %0d want 1", done_cnt); end
    if (last_rx !== d) begin bad++; $display("FAIL bs_rx got %h want %h", last_rx, d); end
    if (seq_word() !== d) begin bad++; $display("FAIL bs_mosi got %h want %h", seq_word(), d); end
    if (busy !== 1'b0) begin bad++; $display("FAIL bs_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    td = 2;
    clear_mon();
    @(negedge clk);
    tx_data = 8'h12;
    start = 1'b1;
    wait_done(1, 400);
    @(negedge clk);
    start = 1'b0;
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart got %b want 1", busy); end
    if (last_gap != 1) begin bad++; $display("FAIL b2b_cs_gap got %0d want 1", last_gap); end
    wait_done(2, 400);
    repeat (10) @(negedge clk);
    total += 2;
    if (done_cnt != 2) begin bad++; $display("FAIL b2b_done got %0d want 2", done_cnt); end
    if (last_rx !== 8'h12) begin bad++; $display("FAIL b2b_rx got %h want 12", last_rx); end
  endtask

  task automatic test_abort();
    logic [W-1:0] d = W'($urandom_range(1, 255));
    int k = 0;
    td = 3;
    clear_mon();
    launch(d);
    wait_done(1, 400);
    total += 1;
    if (rx_data !== d) begin bad++; $display("FAIL ab_pre_rx got %h want %h", rx_data, d); end
    clear_mon();
    launch(~d);
    while (tick_cnt < 6 && k < 200) begin
      @(negedge clk);
      k++;
    end
    total += 1;
    if (sclk !== 1'b1) begin bad++; $display("FAIL ab_mid_sclk got %b want 1", sclk); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total += 4;
    if (cs_n !== 1'b1) begin bad++; $display("FAIL ab_cs got %b want 1", cs_n); end
    if (sclk !== 1'b0) begin bad++; $display("FAIL ab_sclk got %b want 0", sclk); end
    if (rx_data !== '0) begin bad++; $display("FAIL ab_rx got %h want 00", rx_data); end
    if (busy !== 1'b0) begin bad++; $display("FAIL ab_busy got %b want 0", busy); end
    repeat (80) @(negedge clk);
    total += 1;
    if (done_cnt != 0) begin bad++; $display("FAIL ab_done got %0d want 0", done_cnt); end
  endtask

  task automatic test_bit_order();
    logic [W-1:0] d = 8'h01;
    td = 2;
    loop = 1;
    clear_mon();
    launch(d);
    wait_done(1, 400);
    total += 3;
    if (mosi_seq.size() == 0 || mosi_seq[0] !== d[pos(0)]) begin
      bad++;
      $display("FAIL bo_first got %0d bits want first %b", mosi_seq.size(), d[pos(0)]);
    end
    if (last_rx !== d) begin bad++; $display("FAIL bo_rx got %h want %h", last_rx, d); end
    if (seq_word() !== d) begin bad++; $display("FAIL bo_mosi got %h want %h", seq_word(), d); end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    logic [W-1:0] exp;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      td = $urandom_range(1, 5);
      loop = $urandom_range(0, 1);
      slave_word = W'($urandom);
      d = W'($urandom);
      exp = loop ? d : slave_word;
      clear_mon();
      launch(d);
      wait_done(1, 600);
      total += 4;
      if (done_cnt != 1) begin bad++; $display("FAIL rnd%0d_done got %0d want 1", n, done_cnt); end
      if (last_rx !== exp) begin bad++; $display("FAIL rnd%0d_rx got %h want %h", n, last_rx, exp); end
      if (seq_word() !== d) begin bad++; $display("FAIL rnd%0d_mosi got %h want %h", n, seq_word(), d); end
      if (ticks_at_done != 2 * W + 2 || min_per != 2 * td || max_per != 2 * td) begin
        bad++;
        $display("FAIL rnd%0d_timing got ticks=%0d per=%0d..%0d want %0d/%0d",
                 n, ticks_at_done, min_per, max_per, 2 * W + 2, 2 * td);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tx_data = '0;
    test_reset();
    test_loopback();
    test_slave();
    test_busy_start();
    test_back_to_back();
    test_abort();
    test_bit_order();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
